// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM states, default width and counter sizing for serial_subtractor
package serial_sub_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam int DEF_WIDTH = 4;
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: 1-bit subtractor cell, d = x - y - bin with borrow out bo
//   x, y, bin : minuend bit, subtrahend bit, borrow in
//   d, bo     : difference bit, borrow out
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bo
);
   assign d  = x ^ y ^ bin;
   assign bo = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one bit per clock, LSB first
//   clk, rst_n        : clock, async active-low reset
//   start, a, b       : request and operands, captured when idle or done
//   busy, done        : operation in progress, one-cycle result strobe
//   diff, bout, ovf   : (a-b) mod 2^WIDTH, unsigned borrow, signed overflow
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);
   localparam int CW = cnt_w(WIDTH);
   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, r_q, diff_q;
   logic [CW-1:0]    cnt_q;
   logic             brw_q, busy_q, done_q, bout_q, ovf_q;
   logic             d_bit, bo_bit;
   logic [WIDTH-1:0] r_d;
   logic             last_d, ovf_d;
   full_subtractor u_fs (
      .x   (a_q[0]),
      .y   (b_q[0]),
      .bin (brw_q),
      .d   (d_bit),
      .bo  (bo_bit)
   );
   assign r_d    = {d_bit, r_q[WIDTH-1:1]};
   assign last_d = cnt_q == CW'(WIDTH - 1);
   // operands rotate rather than shift, so on the final bit a_q[0]/b_q[0] are the captured MSBs
   assign ovf_d  = (a_q[0] ^ b_q[0]) & (d_bit ^ a_q[0]);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            SHIFT: begin
               a_q   <= {a_q[0], a_q[WIDTH-1:1]};
               b_q   <= {b_q[0], b_q[WIDTH-1:1]};
               r_q   <= r_d;
               brw_q <= bo_bit;
               cnt_q <= cnt_q + CW'(1);
               if (last_d) begin
                  diff_q  <= r_d;
                  bout_q  <= bo_bit;
                  ovf_q   <= ovf_d;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            default: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  brw_q   <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end else begin
                  state_q <= IDLE;
               end
            end
         endcase
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor against an arithmetic model
module tb_serial_subtractor;
   localparam int W = 4;
   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
      int           acc;
   } exp_t;
   logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, bout, ovf;
   logic [W-1:0] diff;
   exp_t         q[$];
   int           errs = 0, checks = 0, cyc = 0, bcnt = 0;
   logic [W-1:0] last_d = '0;
   logic         last_bo = 1'b0, last_ov = 1'b0;
   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string n, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", n, got, exp, cyc);
      end
   endtask
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int acc);
      exp_t e;
      int sx, sy, r;
      sx = int'(x) >= 2**(W-1) ? int'(x) - 2**W : int'(x);
      sy = int'(y) >= 2**(W-1) ? int'(y) - 2**W : int'(y);
      r  = sx - sy;
      e.d   = W'(int'(x) - int'(y));
      e.bo  = x < y;
      e.ov  = r > 2**(W-1) - 1 || r < -(2**(W-1));
      e.acc = acc;
      return e;
   endfunction
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n) begin
         if (busy) begin
            bcnt++;
            chk("hold_during_shift", {diff, bout, ovf}, {last_d, last_bo, last_ov});
         end
         if (done) begin
            if (q.size() == 0) chk("spurious_done", 1, 0);
            else begin
               e = q.pop_front();
               chk("diff", diff, e.d);
               chk("bout", bout, e.bo);
               chk("ovf", ovf, e.ov);
               chk("latency", cyc - e.acc, W);
               chk("busy_cycles", bcnt, W);
               chk("busy_at_done", busy, 0);
               last_d  = e.d;
               last_bo = e.bo;
               last_ov = e.ov;
            end
            bcnt = 0;
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      if (busy) chk("idle_wait", busy, 0);
      a = x;
      b = y;
      start = 1'b1;
      q.push_back(model(x, y, cyc + 1));
      tick();
      start = hold;
      a = W'($urandom);
      b = W'($urandom);
   endtask
   initial begin
      int n;
      #1;
      chk("reset_outputs", {busy, done, diff, bout, ovf}, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      issue(4'b0000, 4'b0000, 0);
      issue(4'b1111, 4'b0101, 0);
      issue(4'b0101, 4'b1010, 0);
      issue(4'b0000, 4'b0001, 1);
      a = 4'b0000;
      b = 4'b0001;
      q.push_back(model(4'b0000, 4'b0001, cyc + W + 1));
      repeat (W + 1) tick();
      start = 1'b0;
      issue(4'b1001, 4'b0010, 0);
      repeat (2) tick();
      a = 4'b0011;
      b = 4'b0001;
      start = 1'b1;
      tick();
      start = 1'b0;
      issue(4'b0110, 4'b0011, 0);
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_outputs", {busy, done, diff, bout, ovf}, 0);
      q.delete();
      last_d = '0;
      last_bo = 1'b0;
      last_ov = 1'b0;
      bcnt = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (W + 3) tick();
      issue(4'b1000, 4'b0001, 0);
      for (int i = 0; i < 24; i++) begin
         issue(W'($urandom), W'($urandom), 0);
         repeat ($urandom_range(0, 1) * $urandom_range(0, W + 2)) tick();
      end
      n = 0;
      while (q.size() > 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain", q.size(), 0);
      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog_timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
